// File: rtl/pc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_ctrl                                                       |
// | Purpose  : Redirect and stall controller for the fetch-stage PC register.|
// |            Arbitrates trap, EX-stage and ID-stage redirects into one      |
// |            jump_en_o/jump_addr_o pair. Generates PC hold and IF/ID, ID/EX |
// |            stall/flush controls. Defers trap entry while a multi-cycle EX |
// |            operation is busy, and counts issued redirects.               |
// | Ports    : clk, rst (sync, active-low)                                   |
// |            trap_req_i/trap_addr_i/ex_pc_i     : trap request, vector, EPC |
// |            ex_jump_en_i/ex_jump_addr_i        : EX branch/JALR redirect   |
// |            id_jump_en_i/id_jump_addr_i        : ID JAL redirect           |
// |            hold_req_i                         : EX unit busy              |
// |            jump_en_o/jump_addr_o              : PC load strobe/value      |
// |            hold_pc_o, stall_if_id_o           : freeze controls           |
// |            flush_if_id_o, flush_id_ex_o       : bubble insertion          |
// |            trap_taken_o, trap_epc_o           : trap pulse / latched EPC  |
// |            redirect_cnt_o                     : issued-redirect counter   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_req_i,
  input  logic [31:0]      trap_addr_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_jump_en_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             id_jump_en_i,
  input  logic [31:0]      id_jump_addr_i,
  input  logic             hold_req_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             hold_pc_o,
  output logic             stall_if_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             trap_taken_o,
  output logic [31:0]      trap_epc_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] TRAP_WAIT = 2'd1;
  localparam logic [1:0] TRAP_MASK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      epc_q   <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (trap_req_i && hold_req_i)
          state_d = TRAP_WAIT;
        else if (trap_req_i)
          state_d = TRAP_MASK;
      end
      // trap_req_i is deliberately not looked at here: once accepted the
      // trap is committed and only waits for the EX unit to go idle.
      TRAP_WAIT: if (!hold_req_i) state_d = TRAP_MASK;
      TRAP_MASK: state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Output logic: all outputs are combinational from state and inputs
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = RESET_ADDR;
    hold_pc_o     = 1'b0;
    stall_if_id_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    trap_fire     = 1'b0;

    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (trap_req_i && !hold_req_i) begin
            trap_fire = 1'b1;
          end else if (trap_req_i) begin
            // Trap accepted but deferred; freeze and drop EX/ID requests.
            hold_pc_o     = 1'b1;
            stall_if_id_o = 1'b1;
          end else if (ex_jump_en_i) begin
            // EX redirect wins over hold: the busy unit is on the wrong path.
            jump_en_o     = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (id_jump_en_i && !hold_req_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = id_jump_addr_i;
            flush_if_id_o = 1'b1;
          end else if (hold_req_i) begin
            // A pending ID redirect is re-presented once hold drops.
            hold_pc_o     = 1'b1;
            stall_if_id_o = 1'b1;
          end
        end
        TRAP_WAIT: begin
          if (!hold_req_i) begin
            trap_fire = 1'b1;
          end else begin
            hold_pc_o     = 1'b1;
            stall_if_id_o = 1'b1;
          end
        end
        TRAP_MASK: begin
          // EX/ID requests in this cycle belong to the wrong path.
          hold_pc_o     = hold_req_i;
          stall_if_id_o = hold_req_i;
        end
        default: ;
      endcase

      if (trap_fire) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = trap_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  // Datapath next-state: EPC capture and redirect counter
  always_comb begin
    epc_d = trap_fire ? ex_pc_i : epc_q;
    cnt_d = jump_en_o ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign trap_taken_o   = trap_fire;
  assign trap_epc_o     = epc_q;
  assign redirect_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_ctrl                                                    |
// | Purpose  : Directed self-checking bench for pc_ctrl.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pc_ctrl;

  localparam logic [31:0] RST_ADDR = 32'h0000_0A00;
  localparam int          CW       = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          trap_req_i;
  logic [31:0]   trap_addr_i;
  logic [31:0]   ex_pc_i;
  logic          ex_jump_en_i;
  logic [31:0]   ex_jump_addr_i;
  logic          id_jump_en_i;
  logic [31:0]   id_jump_addr_i;
  logic          hold_req_i;
  logic          jump_en_o;
  logic [31:0]   jump_addr_o;
  logic          hold_pc_o;
  logic          stall_if_id_o;
  logic          flush_if_id_o;
  logic          flush_id_ex_o;
  logic          trap_taken_o;
  logic [31:0]   trap_epc_o;
  logic [CW-1:0] redirect_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // {jump_en, hold_pc, stall_if_id, flush_if_id, flush_id_ex, trap_taken}
  logic [5:0] flags;
  assign flags = {jump_en_o, hold_pc_o, stall_if_id_o,
                  flush_if_id_o, flush_id_ex_o, trap_taken_o};

  always #5 clk = ~clk;

  pc_ctrl #(.RESET_ADDR(RST_ADDR), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req_i     (trap_req_i),
    .trap_addr_i    (trap_addr_i),
    .ex_pc_i        (ex_pc_i),
    .ex_jump_en_i   (ex_jump_en_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .id_jump_en_i   (id_jump_en_i),
    .id_jump_addr_i (id_jump_addr_i),
    .hold_req_i     (hold_req_i),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .trap_taken_o   (trap_taken_o),
    .trap_epc_o     (trap_epc_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    trap_req_i     = 1'b0;
    trap_addr_i    = 32'h0;
    ex_pc_i        = 32'h0;
    ex_jump_en_i   = 1'b0;
    ex_jump_addr_i = 32'h0;
    id_jump_en_i   = 1'b0;
    id_jump_addr_i = 32'h0;
    hold_req_i     = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b0;
    trap_req_i = 1'b1; trap_addr_i = 32'h777;
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h123; hold_req_i = 1'b1;
    #1;
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags: got %b want %b", flags, 6'b000000);
    end
    n_checks++;
    if (jump_addr_o !== RST_ADDR) begin
      n_fail++; $display("FAIL reset_addr: got %h want %h", jump_addr_o, RST_ADDR);
    end
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_cnt_o !== 4'd0 || trap_epc_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got cnt=%0d epc=%h want cnt=0 epc=0", redirect_cnt_o, trap_epc_o);
    end
    n_checks++;
    if (flags !== 6'b000000 || jump_addr_o !== RST_ADDR) begin
      n_fail++; $display("FAIL idle_after_reset: got %b/%h want 000000/%h", flags, jump_addr_o, RST_ADDR);
    end
  endtask

  task automatic test_ex_redirect();
    next_cycle();
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h100;
    #1;
    n_checks++;
    if (flags !== 6'b100110 || jump_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL ex_redirect: got %b/%h want 100110/00000100", flags, jump_addr_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL ex_cnt: got %0d want 1", redirect_cnt_o);
    end
  endtask

  task automatic test_ex_id_same_cycle();
    next_cycle();
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h200;
    id_jump_en_i = 1'b1; id_jump_addr_i = 32'h300;
    hold_req_i   = 1'b1;  // EX redirect must override hold
    #1;
    n_checks++;
    if (flags !== 6'b100110 || jump_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL ex_over_id: got %b/%h want 100110/00000200", flags, jump_addr_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_cnt_o !== 4'd2) begin
      n_fail++; $display("FAIL ex_id_cnt: got %0d want 2", redirect_cnt_o);
    end
  endtask

  task automatic test_id_under_hold();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      id_jump_en_i = 1'b1; id_jump_addr_i = 32'h40; hold_req_i = 1'b1;
      #1;
      n_checks++;
      if (flags !== 6'b011000 || jump_addr_o !== RST_ADDR) begin
        n_fail++; $display("FAIL id_held[%0d]: got %b/%h want 011000/%h", c, flags, jump_addr_o, RST_ADDR);
      end
    end
    next_cycle();
    hold_req_i = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b100100 || jump_addr_o !== 32'h40) begin
      n_fail++; $display("FAIL id_release: got %b/%h want 100100/00000040", flags, jump_addr_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_cnt_o !== 4'd3) begin
      n_fail++; $display("FAIL id_cnt: got %0d want 3", redirect_cnt_o);
    end
  endtask

  task automatic test_trap_deferred();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      trap_req_i = 1'b1; trap_addr_i = 32'h800; ex_pc_i = 32'h88; hold_req_i = 1'b1;
      // An EX request during TRAP_WAIT must be dropped.
      ex_jump_en_i = (c == 2); ex_jump_addr_i = 32'h654;
      #1;
      n_checks++;
      if (flags !== 6'b011000 || jump_addr_o !== RST_ADDR) begin
        n_fail++; $display("FAIL trap_wait[%0d]: got %b/%h want 011000/%h", c, flags, jump_addr_o, RST_ADDR);
      end
    end
    next_cycle();
    hold_req_i = 1'b0; ex_jump_en_i = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b100111 || jump_addr_o !== 32'h800) begin
      n_fail++; $display("FAIL trap_fire: got %b/%h want 100111/00000800", flags, jump_addr_o);
    end
    // TRAP_MASK cycle: EX redirect is wrong-path.
    next_cycle();
    trap_req_i = 1'b0; ex_pc_i = 32'h99;
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h500;
    #1;
    n_checks++;
    if (flags !== 6'b000000 || jump_addr_o !== RST_ADDR) begin
      n_fail++; $display("FAIL trap_mask: got %b/%h want 000000/%h", flags, jump_addr_o, RST_ADDR);
    end
    n_checks++;
    if (trap_epc_o !== 32'h88 || redirect_cnt_o !== 4'd4) begin
      n_fail++; $display("FAIL trap_epc_cnt: got epc=%h cnt=%0d want epc=00000088 cnt=4", trap_epc_o, redirect_cnt_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (trap_epc_o !== 32'h88 || redirect_cnt_o !== 4'd4) begin
      n_fail++; $display("FAIL trap_mask_cnt: got epc=%h cnt=%0d want epc=00000088 cnt=4", trap_epc_o, redirect_cnt_o);
    end
  endtask

  task automatic test_trap_immediate();
    next_cycle();
    trap_req_i = 1'b1; trap_addr_i = 32'h900; ex_pc_i = 32'h44;
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h210;
    id_jump_en_i = 1'b1; id_jump_addr_i = 32'h310;
    #1;
    n_checks++;
    if (flags !== 6'b100111 || jump_addr_o !== 32'h900) begin
      n_fail++; $display("FAIL trap_priority: got %b/%h want 100111/00000900", flags, jump_addr_o);
    end
    // TRAP_MASK honours hold.
    next_cycle();
    trap_req_i = 1'b0; hold_req_i = 1'b1;
    #1;
    n_checks++;
    if (flags !== 6'b011000 || trap_epc_o !== 32'h44 || redirect_cnt_o !== 4'd5) begin
      n_fail++; $display("FAIL mask_hold: got %b epc=%h cnt=%0d want 011000 epc=00000044 cnt=5", flags, trap_epc_o, redirect_cnt_o);
    end
    // Back in RUN: EX redirect accepted again.
    next_cycle();
    hold_req_i = 1'b0; id_jump_en_i = 1'b0;
    ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h220;
    #1;
    n_checks++;
    if (flags !== 6'b100110 || jump_addr_o !== 32'h220) begin
      n_fail++; $display("FAIL after_mask_ex: got %b/%h want 100110/00000220", flags, jump_addr_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    next_cycle();
    trap_req_i = 1'b1; trap_addr_i = 32'hA00; ex_pc_i = 32'hCC; hold_req_i = 1'b1;
    next_cycle();  // now in TRAP_WAIT
    rst = 1'b0; hold_req_i = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b000000 || jump_addr_o !== RST_ADDR) begin
      n_fail++; $display("FAIL rst_in_wait: got %b/%h want 000000/%h", flags, jump_addr_o, RST_ADDR);
    end
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if (flags !== 6'b000000 || redirect_cnt_o !== 4'd0 || trap_epc_o !== 32'h0) begin
      n_fail++; $display("FAIL after_rst_wait: got %b cnt=%0d epc=%h want 000000 cnt=0 epc=0", flags, redirect_cnt_o, trap_epc_o);
    end
    // State must be RUN: a plain ID redirect goes straight through.
    next_cycle();
    id_jump_en_i = 1'b1; id_jump_addr_i = 32'h60;
    #1;
    n_checks++;
    if (flags !== 6'b100100 || jump_addr_o !== 32'h60) begin
      n_fail++; $display("FAIL run_after_rst: got %b/%h want 100100/00000060", flags, jump_addr_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_counter_wrap();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 17; c++) begin
      next_cycle();
      ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h1000 + 32'(c * 4);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL cnt_wrap: got %0d want 1", redirect_cnt_o);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_ex_redirect();
    test_ex_id_same_cycle();
    test_id_under_hold();
    test_trap_deferred();
    test_trap_immediate();
    test_reset_in_wait();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
